// File: rtl/rpsc_power_sequencer.sv
// ---------------------------------------------------------------------------
// rpsc_power_sequencer
// Supply-sequencing controller for the RF power stage. Powers up the cooling
// fan, cathode (CA) supply with warm-up, G1, G2 and anode in that order, then
// grants the RF permit. Tears supplies down in reverse order on a stop
// request, and latches a coded fault on emergency, interlock loss, supply
// acknowledge timeout or loss of an acknowledged supply.
//
// Ports:
//   clk, reset (async, active-low)
//   i_start / i_stop          operator power-up / orderly power-down levels
//   i_interlocks_ok           combined interlock chain
//   i_emergency               emergency stop, active high
//   i_fault_clear             operator fault acknowledge
//   i_fan_ok .. i_an_ok       per-supply OK feedback
//   o_fan_on .. o_an_on       per-supply enables (registered)
//   o_rf_permit, o_ready      RF drive permit / in RUN (registered)
//   o_fault, o_fault_code     latched fault flag and code (registered)
//   o_state                   encoded current state for diagnostics
// ---------------------------------------------------------------------------
module rpsc_power_sequencer #(
    parameter int CNT_W        = 16,
    parameter int STEP_TIMEOUT = 200,
    parameter int CA_WARMUP    = 1000,
    parameter int SEQ_GAP      = 10,
    parameter int FAN_RUNDOWN  = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_interlocks_ok,
    input  logic       i_emergency,
    input  logic       i_fault_clear,
    input  logic       i_fan_ok,
    input  logic       i_ca_ok,
    input  logic       i_g1_ok,
    input  logic       i_g2_ok,
    input  logic       i_an_ok,
    output logic       o_fan_on,
    output logic       o_ca_on,
    output logic       o_g1_on,
    output logic       o_g2_on,
    output logic       o_an_on,
    output logic       o_rf_permit,
    output logic       o_ready,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FAN   = 4'd1,
        ST_CA    = 4'd2,
        ST_WARM  = 4'd3,
        ST_G1    = 4'd4,
        ST_G2    = 4'd5,
        ST_AN    = 4'd6,
        ST_RUN   = 4'd7,
        ST_SHDN  = 4'd8,
        ST_FAULT = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(STEP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WARM_LAST    = CNT_W'(CA_WARMUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(SEQ_GAP - 1);
    localparam logic [CNT_W-1:0] RUNDOWN_LAST = CNT_W'(FAN_RUNDOWN - 1);

    // Enable vector layout: bit0 fan, bit1 CA, bit2 G1, bit3 G2, bit4 anode,
    // bit5 RF permit. Teardown always removes the highest set bit above fan.
    function automatic logic [5:0] drop_highest(input logic [5:0] en);
        logic [5:0] res;
        res = en;
        if (en[5]) begin
            res[5] = 1'b0;
        end else if (en[4]) begin
            res[4] = 1'b0;
        end else if (en[3]) begin
            res[3] = 1'b0;
        end else if (en[2]) begin
            res[2] = 1'b0;
        end else if (en[1]) begin
            res[1] = 1'b0;
        end else begin
            res = en;
        end
        return res;
    endfunction

    // Supply fault code of the lowest-order lost supply (fan=1 .. anode=5).
    function automatic logic [2:0] lowest_code(input logic [4:0] m);
        logic [2:0] code;
        if (m[0]) begin
            code = 3'd1;
        end else if (m[1]) begin
            code = 3'd2;
        end else if (m[2]) begin
            code = 3'd3;
        end else if (m[3]) begin
            code = 3'd4;
        end else if (m[4]) begin
            code = 3'd5;
        end else begin
            code = 3'd0;
        end
        return code;
    endfunction

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [5:0]       en_r, en_n;
    logic             ready_r, ready_n;
    logic             fault_r, fault_n;
    logic [2:0]       code_r, code_n;
    logic             armed_r, armed_n;

    logic [4:0]       ok_s;
    logic [4:0]       acked_s;
    logic [4:0]       lost_s;
    logic             is_step_s;
    logic             step_ok_s;
    logic [2:0]       step_code_s;
    state_t           step_next_s;
    logic             trip_s;
    logic [2:0]       trip_code_s;

    assign ok_s   = {i_an_ok, i_g2_ok, i_g1_ok, i_ca_ok, i_fan_ok};
    assign lost_s = acked_s & ~ok_s;

    // Per-state view of the supply being waited for and the supplies already acknowledged.
    always_comb begin
        is_step_s   = 1'b0;
        step_ok_s   = 1'b0;
        step_code_s = 3'd0;
        step_next_s = state_r;
        acked_s     = 5'b00000;
        case (state_r)
            ST_FAN:  begin is_step_s = 1'b1; step_ok_s = ok_s[0]; step_code_s = 3'd1; step_next_s = ST_CA;   end
            ST_CA:   begin is_step_s = 1'b1; step_ok_s = ok_s[1]; step_code_s = 3'd2; step_next_s = ST_WARM; end
            ST_WARM: begin acked_s = 5'b00011; end
            ST_G1:   begin is_step_s = 1'b1; step_ok_s = ok_s[2]; step_code_s = 3'd3; step_next_s = ST_G2; acked_s = 5'b00011; end
            ST_G2:   begin is_step_s = 1'b1; step_ok_s = ok_s[3]; step_code_s = 3'd4; step_next_s = ST_AN; acked_s = 5'b00111; end
            ST_AN:   begin is_step_s = 1'b1; step_ok_s = ok_s[4]; step_code_s = 3'd5; step_next_s = ST_RUN; acked_s = 5'b01111; end
            ST_RUN:  begin acked_s = 5'b11111; end
            default: begin acked_s = 5'b00000; end
        endcase
    end

    // Fault detection in priority order: emergency, interlock, supply loss, step timeout.
    always_comb begin
        trip_s      = 1'b0;
        trip_code_s = 3'd0;
        if ((state_r != ST_FAULT) && i_emergency) begin
            trip_s      = 1'b1;
            trip_code_s = 3'd7;
        end else if ((state_r != ST_FAULT) && (state_r != ST_IDLE) && !i_interlocks_ok) begin
            trip_s      = 1'b1;
            trip_code_s = 3'd6;
        end else if (|lost_s) begin
            trip_s      = 1'b1;
            trip_code_s = lowest_code(lost_s);
        end else if (is_step_s && !step_ok_s && (cnt_r >= TIMEOUT_LAST)) begin
            trip_s      = 1'b1;
            trip_code_s = step_code_s;
        end else begin
            trip_s      = 1'b0;
            trip_code_s = 3'd0;
        end
    end

    // Next-state, counter and next-output computation.
    always_comb begin
        state_n = state_r;
        en_n    = en_r;
        fault_n = fault_r;
        code_n  = code_r;
        armed_n = armed_r;
        cnt_n   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

        case (state_r)
            ST_IDLE: begin
                // Start is level-sensitive but must be seen low in IDLE before it counts.
                armed_n = armed_r | ~i_start;
                if (armed_r && i_start && !i_stop && i_interlocks_ok && !i_emergency) begin
                    state_n = ST_FAN;
                    armed_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FAN, ST_CA, ST_G1, ST_G2, ST_AN: begin
                if (i_stop) begin
                    state_n = ST_SHDN;
                end else if (step_ok_s) begin
                    state_n = step_next_s;
                end else begin
                    state_n = state_r;
                end
            end
            ST_WARM: begin
                if (i_stop) begin
                    state_n = ST_SHDN;
                end else if (cnt_r >= WARM_LAST) begin
                    state_n = ST_G1;
                end else begin
                    state_n = ST_WARM;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_n = ST_SHDN;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_SHDN: begin
                // Drop one raised enable per gap; once only the fan is left, run it down.
                if (|en_r[5:1]) begin
                    if (cnt_r >= GAP_LAST) begin
                        en_n  = drop_highest(en_r);
                        cnt_n = CNT_ZERO;
                    end else begin
                        en_n = en_r;
                    end
                end else if (cnt_r >= RUNDOWN_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_SHDN;
                end
            end
            ST_FAULT: begin
                if (en_r[0] && (cnt_r >= RUNDOWN_LAST)) begin
                    en_n[0] = 1'b0;
                end else if (!en_r[0] && i_fault_clear && !i_emergency && i_interlocks_ok) begin
                    state_n = ST_IDLE;
                    armed_n = 1'b0;
                end else begin
                    state_n = ST_FAULT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (trip_s) begin
            state_n = ST_FAULT;
            fault_n = 1'b1;
            code_n  = trip_code_s;
        end else begin
            fault_n = fault_n;
        end

        if (state_n != state_r) begin
            cnt_n = CNT_ZERO;
        end else begin
            cnt_n = cnt_n;
        end

        ready_n = (state_n == ST_RUN);

        case (state_n)
            ST_IDLE: begin
                en_n    = 6'b000000;
                fault_n = 1'b0;
                code_n  = 3'd0;
            end
            ST_FAN:           en_n = 6'b000001;
            ST_CA, ST_WARM:   en_n = 6'b000011;
            ST_G1:            en_n = 6'b000111;
            ST_G2:            en_n = 6'b001111;
            ST_AN:            en_n = 6'b011111;
            ST_RUN:           en_n = 6'b111111;
            ST_SHDN: begin
                // The first teardown step happens on the entry edge itself.
                en_n = (state_r != ST_SHDN) ? drop_highest(en_r) : en_n;
            end
            ST_FAULT: begin
                en_n[5:1] = 5'b00000;
                if ((state_r != ST_FAULT) && (trip_code_s == 3'd7)) begin
                    en_n[0] = 1'b0;
                end else begin
                    en_n[0] = en_n[0];
                end
            end
            default: en_n = 6'b000000;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            en_r    <= 6'b000000;
            ready_r <= 1'b0;
            fault_r <= 1'b0;
            code_r  <= 3'd0;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            en_r    <= en_n;
            ready_r <= ready_n;
            fault_r <= fault_n;
            code_r  <= code_n;
            armed_r <= armed_n;
        end
    end

    assign o_fan_on     = en_r[0];
    assign o_ca_on      = en_r[1];
    assign o_g1_on      = en_r[2];
    assign o_g2_on      = en_r[3];
    assign o_an_on      = en_r[4];
    assign o_rf_permit  = en_r[5];
    assign o_ready      = ready_r;
    assign o_fault      = fault_r;
    assign o_fault_code = code_r;
    assign o_state      = state_r;

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// Directed testbench for rpsc_power_sequencer. Expected values are hand-derived
// cycle positions relative to each state entry edge.
module tb_rpsc_power_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start, i_stop, i_interlocks_ok, i_emergency, i_fault_clear;
    logic       i_fan_ok, i_ca_ok, i_g1_ok, i_g2_ok, i_an_ok;
    logic       o_fan_on, o_ca_on, o_g1_on, o_g2_on, o_an_on, o_rf_permit;
    logic       o_ready, o_fault;
    logic [2:0] o_fault_code;
    logic [3:0] o_state;
    logic [7:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // fan ca g1 g2 an rf ready fault
    assign outs = {o_fan_on, o_ca_on, o_g1_on, o_g2_on, o_an_on, o_rf_permit, o_ready, o_fault};

    rpsc_power_sequencer dut (
        .clk(clk), .reset(reset),
        .i_start(i_start), .i_stop(i_stop), .i_interlocks_ok(i_interlocks_ok),
        .i_emergency(i_emergency), .i_fault_clear(i_fault_clear),
        .i_fan_ok(i_fan_ok), .i_ca_ok(i_ca_ok), .i_g1_ok(i_g1_ok),
        .i_g2_ok(i_g2_ok), .i_an_ok(i_an_ok),
        .o_fan_on(o_fan_on), .o_ca_on(o_ca_on), .o_g1_on(o_g1_on),
        .o_g2_on(o_g2_on), .o_an_on(o_an_on), .o_rf_permit(o_rf_permit),
        .o_ready(o_ready), .o_fault(o_fault), .o_fault_code(o_fault_code),
        .o_state(o_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_oks();
        {i_fan_ok, i_ca_ok, i_g1_ok, i_g2_ok, i_an_ok} = 5'b00000;
    endtask

    // Stimulus only: from IDLE, returns right after the edge entering state 'target'.
    task automatic bring_up(input int target);
        i_start = 1'b0; tick();
        i_start = 1'b1; tick();
        i_start = 1'b0;
        if (target >= 2) begin tick(); tick(); i_fan_ok = 1'b1; tick(); end
        if (target >= 3) begin tick(); tick(); i_ca_ok = 1'b1; tick(); end
        if (target >= 4) begin repeat (1000) tick(); end
        if (target >= 5) begin tick(); tick(); i_g1_ok = 1'b1; tick(); end
        if (target >= 6) begin tick(); tick(); i_g2_ok = 1'b1; tick(); end
        if (target >= 7) begin tick(); tick(); i_an_ok = 1'b1; tick(); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_start = 1'b0; i_stop = 1'b0; i_interlocks_ok = 1'b1;
        i_emergency = 1'b0; i_fault_clear = 1'b0;
        clear_oks();
        repeat (3) tick();
        n_cmp++; if (o_state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
        n_cmp++; if (outs !== 8'b0000_0000) begin n_bad++; $display("FAIL reset_outs: got %b want 00000000", outs); end
        n_cmp++; if (o_fault_code !== 3'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", o_fault_code); end
        reset = 1'b1;
        tick();
        n_cmp++; if (o_state !== 4'd0) begin n_bad++; $display("FAIL post_reset_state: got %0d want 0", o_state); end
    endtask

    task automatic test_powerup();
        i_start = 1'b0; tick();
        i_start = 1'b1; tick();
        n_cmp++; if (o_state !== 4'd1) begin n_bad++; $display("FAIL pu_fan_state: got %0d want 1", o_state); end
        n_cmp++; if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL pu_fan_outs: got %b want 10000000", outs); end
        tick(); tick();
        n_cmp++; if (o_state !== 4'd1) begin n_bad++; $display("FAIL pu_fan_wait: got %0d want 1", o_state); end
        i_fan_ok = 1'b1; tick();
        n_cmp++; if (o_state !== 4'd2) begin n_bad++; $display("FAIL pu_ca_state: got %0d want 2", o_state); end
        n_cmp++; if (outs !== 8'b1100_0000) begin n_bad++; $display("FAIL pu_ca_outs: got %b want 11000000", outs); end
        i_start = 1'b0;
        tick(); tick(); i_ca_ok = 1'b1; tick();
        n_cmp++; if (o_state !== 4'd3) begin n_bad++; $display("FAIL pu_warm_state: got %0d want 3", o_state); end
        repeat (999) tick();
        n_cmp++; if ({o_state, outs} !== {4'd3, 8'b1100_0000}) begin n_bad++; $display("FAIL pu_warm_end: got %0d/%b want 3/11000000", o_state, outs); end
        tick();
        n_cmp++; if ({o_state, outs} !== {4'd4, 8'b1110_0000}) begin n_bad++; $display("FAIL pu_g1: got %0d/%b want 4/11100000", o_state, outs); end
        tick(); tick(); i_g1_ok = 1'b1; tick();
        n_cmp++; if ({o_state, outs} !== {4'd5, 8'b1111_0000}) begin n_bad++; $display("FAIL pu_g2: got %0d/%b want 5/11110000", o_state, outs); end
        tick(); tick(); i_g2_ok = 1'b1; tick();
        n_cmp++; if ({o_state, outs} !== {4'd6, 8'b1111_1000}) begin n_bad++; $display("FAIL pu_an: got %0d/%b want 6/11111000", o_state, outs); end
        tick(); tick(); i_an_ok = 1'b1; tick();
        n_cmp++; if ({o_state, outs} !== {4'd7, 8'b1111_1110}) begin n_bad++; $display("FAIL pu_run: got %0d/%b want 7/11111110", o_state, outs); end
        n_cmp++; if (o_fault_code !== 3'd0) begin n_bad++; $display("FAIL pu_code: got %0d want 0", o_fault_code); end
    endtask

    task automatic test_stop_from_run();
        i_stop = 1'b1; tick();
        n_cmp++; if ({o_state, outs} !== {4'd8, 8'b1111_1000}) begin n_bad++; $display("FAIL stop_entry: got %0d/%b want 8/11111000", o_state, outs); end
        i_ca_ok = 1'b0;  // loss of feedback during shutdown must be ignored
        repeat (9) tick();
        n_cmp++; if ({o_state, outs} !== {4'd8, 8'b1111_1000}) begin n_bad++; $display("FAIL stop_gap_hold: got %0d/%b want 8/11111000", o_state, outs); end
        tick();
        n_cmp++; if ({o_state, outs} !== {4'd8, 8'b1111_0000}) begin n_bad++; $display("FAIL stop_an_drop: got %0d/%b want 8/11110000", o_state, outs); end
        repeat (10) tick();
        n_cmp++; if (outs !== 8'b1110_0000) begin n_bad++; $display("FAIL stop_g2_drop: got %b want 11100000", outs); end
        repeat (10) tick();
        n_cmp++; if (outs !== 8'b1100_0000) begin n_bad++; $display("FAIL stop_g1_drop: got %b want 11000000", outs); end
        repeat (10) tick();
        n_cmp++; if ({o_state, outs} !== {4'd8, 8'b1000_0000}) begin n_bad++; $display("FAIL stop_ca_drop: got %0d/%b want 8/10000000", o_state, outs); end
        repeat (499) tick();
        n_cmp++; if ({o_state, outs} !== {4'd8, 8'b1000_0000}) begin n_bad++; $display("FAIL stop_rundown: got %0d/%b want 8/10000000", o_state, outs); end
        tick();
        n_cmp++; if ({o_state, outs} !== {4'd0, 8'b0000_0000}) begin n_bad++; $display("FAIL stop_idle: got %0d/%b want 0/00000000", o_state, outs); end
        i_stop = 1'b0;
        clear_oks();
    endtask

    task automatic test_start_stop_idle();
        i_start = 1'b0; tick();
        i_start = 1'b1; i_stop = 1'b1;
        repeat (5) tick();
        n_cmp++; if ({o_state, outs} !== {4'd0, 8'b0000_0000}) begin n_bad++; $display("FAIL start_stop_idle: got %0d/%b want 0/00000000", o_state, outs); end
        i_start = 1'b0; i_stop = 1'b0;
        tick();
    endtask

    task automatic test_g2_timeout();
        bring_up(5);
        n_cmp++; if ({o_state, outs} !== {4'd5, 8'b1111_0000}) begin n_bad++; $display("FAIL to_g2_entry: got %0d/%b want 5/11110000", o_state, outs); end
        repeat (199) tick();
        n_cmp++; if (o_state !== 4'd5) begin n_bad++; $display("FAIL to_before: got %0d want 5", o_state); end
        tick();
        n_cmp++; if ({o_state, outs} !== {4'd9, 8'b1000_0001}) begin n_bad++; $display("FAIL to_fault: got %0d/%b want 9/10000001", o_state, outs); end
        n_cmp++; if (o_fault_code !== 3'd4) begin n_bad++; $display("FAIL to_code: got %0d want 4", o_fault_code); end
        i_fault_clear = 1'b1; i_start = 1'b1;
        repeat (499) tick();
        n_cmp++; if ({o_state, outs} !== {4'd9, 8'b1000_0001}) begin n_bad++; $display("FAIL to_rundown: got %0d/%b want 9/10000001", o_state, outs); end
        tick();
        n_cmp++; if ({o_state, outs} !== {4'd9, 8'b0000_0001}) begin n_bad++; $display("FAIL to_fan_drop: got %0d/%b want 9/00000001", o_state, outs); end
        tick();
        n_cmp++; if ({o_state, outs, o_fault_code} !== {4'd0, 8'b0000_0000, 3'd0}) begin n_bad++; $display("FAIL to_clear: got %0d/%b/%0d want 0/00000000/0", o_state, outs, o_fault_code); end
        repeat (3) tick();
        n_cmp++; if (o_state !== 4'd0) begin n_bad++; $display("FAIL to_no_restart: got %0d want 0", o_state); end
        i_fault_clear = 1'b0; i_start = 1'b0;
        clear_oks();
        tick();
    endtask

    task automatic test_emergency_warm();
        bring_up(3);
        repeat (10) tick();
        n_cmp++; if (o_state !== 4'd3) begin n_bad++; $display("FAIL em_warm: got %0d want 3", o_state); end
        i_emergency = 1'b1; tick();
        n_cmp++; if ({o_state, outs, o_fault_code} !== {4'd9, 8'b0000_0001, 3'd7}) begin n_bad++; $display("FAIL em_fault: got %0d/%b/%0d want 9/00000001/7", o_state, outs, o_fault_code); end
        i_fault_clear = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({o_state, o_fault_code} !== {4'd9, 3'd7}) begin n_bad++; $display("FAIL em_clear_reject: got %0d/%0d want 9/7", o_state, o_fault_code); end
        i_emergency = 1'b0; tick();
        n_cmp++; if ({o_state, outs} !== {4'd0, 8'b0000_0000}) begin n_bad++; $display("FAIL em_clear_accept: got %0d/%b want 0/00000000", o_state, outs); end
        i_fault_clear = 1'b0;
        clear_oks();
        tick();
    endtask

    task automatic test_an_loss_run();
        bring_up(7);
        n_cmp++; if (o_state !== 4'd7) begin n_bad++; $display("FAIL anl_run: got %0d want 7", o_state); end
        i_an_ok = 1'b0; tick();
        n_cmp++; if ({o_state, outs, o_fault_code} !== {4'd9, 8'b1000_0001, 3'd5}) begin n_bad++; $display("FAIL anl_fault: got %0d/%b/%0d want 9/10000001/5", o_state, outs, o_fault_code); end
    endtask

    task automatic test_reset_mid_ca();
        reset = 1'b0; tick();
        reset = 1'b1; clear_oks(); tick();
        bring_up(2);
        tick();
        n_cmp++; if ({o_state, outs} !== {4'd2, 8'b1100_0000}) begin n_bad++; $display("FAIL rst_ca: got %0d/%b want 2/11000000", o_state, outs); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({o_state, outs, o_fault_code} !== {4'd0, 8'b0000_0000, 3'd0}) begin n_bad++; $display("FAIL rst_async: got %0d/%b/%0d want 0/00000000/0", o_state, outs, o_fault_code); end
        tick();
        reset = 1'b1; clear_oks();
        tick();
    endtask

    task automatic test_interlock_shdn();
        bring_up(2);
        i_stop = 1'b1; tick();
        n_cmp++; if ({o_state, outs} !== {4'd8, 8'b1000_0000}) begin n_bad++; $display("FAIL il_shdn: got %0d/%b want 8/10000000", o_state, outs); end
        i_stop = 1'b0;
        repeat (5) tick();
        i_interlocks_ok = 1'b0; tick();
        n_cmp++; if ({o_state, outs, o_fault_code} !== {4'd9, 8'b1000_0001, 3'd6}) begin n_bad++; $display("FAIL il_fault: got %0d/%b/%0d want 9/10000001/6", o_state, outs, o_fault_code); end
        i_interlocks_ok = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_stop_from_run();
        test_start_stop_idle();
        test_g2_timeout();
        test_emergency_warm();
        test_an_loss_run();
        test_reset_mid_ca();
        test_interlock_shdn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
